// File: rtl/fluid_pkg.sv
// Shared fixed-point constants and the arbiter state encoding.
//   FX_WIDTH    : Q16.16 word width
//   FX_FRAC     : number of fractional bits
//   arb_state_t : IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE
package fluid_pkg;
    localparam int FX_WIDTH = 32;
    localparam int FX_FRAC  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : index with highest priority this round
//   winner_o : first set request at or above ptr_i, wrapping
//   valid_o  : any request set
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [IW-1:0]    winner_o,
    output logic             valid_o
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    // Rotating a doubled copy puts ptr_i at bit 0, so the lowest set bit of
    // rot is the winner's distance from the pointer.
    assign dbl     = {req_i, req_i};
    assign rot     = N_REQ'(dbl >> ptr_i);
    assign valid_o = |req_i;

    always_comb begin
        winner_o = '0;
        // Descending scan: the last hit is the smallest distance.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner_o = IW'((int'(ptr_i) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/norm_arbiter.sv
// Shares one multi-cycle norm unit between N_REQ requesters.
//   req/req_x/req_y          : requester levels and packed Q16.16 operands
//   resp_done/resp_xn/resp_yn: one-hot done pulse to the owner plus result
//   norm_start/norm_x/norm_y : start pulse and operands to the norm unit
//   norm_done/norm_xn/norm_yn: done pulse and result from the norm unit
//   busy, grant_id           : arbiter status
//   timeout_err, err_clr     : sticky watchdog flag and its clear
//   dbg_state                : current FSM state
// Handshake: a requester raises req[i] with operands valid and holds both
// until resp_done[i] pulses for one cycle; resp_xn/resp_yn are valid only in
// that cycle. Toward the norm unit, norm_start is a one-cycle pulse with
// norm_x/norm_y stable until norm_done pulses for one cycle.
module norm_arbiter
    import fluid_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = FX_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_x,
    input  logic [N_REQ*WIDTH-1:0] req_y,
    output logic [N_REQ-1:0]       resp_done,
    output logic [WIDTH-1:0]       resp_xn,
    output logic [WIDTH-1:0]       resp_yn,
    output logic                   norm_start,
    output logic [WIDTH-1:0]       norm_x,
    output logic [WIDTH-1:0]       norm_y,
    input  logic [WIDTH-1:0]       norm_xn,
    input  logic [WIDTH-1:0]       norm_yn,
    input  logic                   norm_done,
    output logic                   busy,
    output logic [IW-1:0]          grant_id,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output arb_state_t             dbg_state
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0] op_x_q, op_x_d, op_y_q, op_y_d;
    logic [WIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic [WIDTH-1:0] slot_x [N_REQ];
    logic [WIDTH-1:0] slot_y [N_REQ];
    logic             timeout_hit;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        assign slot_x[g] = req_x[g*WIDTH +: WIDTH];
        assign slot_y[g] = req_y[g*WIDTH +: WIDTH];
    end

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (pick_idx),
        .valid_o  (pick_valid)
    );

    // A done arriving on the last counted cycle beats the timeout.
    assign timeout_hit = (state_q == WAIT) && !norm_done && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (norm_done || (cnt_q == CNT_LAST)) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: decoded from state so reset drops them asynchronously.
    always_comb begin
        norm_start = (state_q == ISSUE);
        busy       = (state_q != IDLE);
        resp_done  = '0;
        if (state_q == RESPOND) resp_done[grant_q] = 1'b1;
    end

    // Datapath next-state
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        op_x_d  = op_x_q;
        op_y_d  = op_y_q;
        res_x_d = res_x_q;
        res_y_d = res_y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    op_x_d  = slot_x[pick_idx];
                    op_y_d  = slot_y[pick_idx];
                    ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
                end
            end
            ISSUE: cnt_d = '0;
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (norm_done) begin
                    res_x_d = norm_xn;
                    res_y_d = norm_yn;
                end else if (cnt_q == CNT_LAST) begin
                    res_x_d = '0;
                    res_y_d = '0;
                end
            end
            default: ;
        endcase
        // Set has priority over clear.
        err_d = err_q;
        if (timeout_hit)  err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            grant_q <= '0;
            op_x_q  <= '0;
            op_y_q  <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op_x_q  <= op_x_d;
            op_y_q  <= op_y_d;
            res_x_q <= res_x_d;
            res_y_q <= res_y_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign norm_x      = op_x_q;
    assign norm_y      = op_y_q;
    assign resp_xn     = res_x_q;
    assign resp_yn     = res_y_q;
    assign grant_id    = grant_q;
    assign timeout_err = err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_norm_arbiter.sv
// Directed bench for norm_arbiter with a behavioural norm unit and a
// scoreboard of expected {resp_done, xn, yn} tuples.
module tb_norm_arbiter;
    import fluid_pkg::*;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk, rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_x, req_y;
    logic [N-1:0]   resp_done;
    logic [W-1:0]   resp_xn, resp_yn;
    logic           norm_start;
    logic [W-1:0]   norm_x, norm_y, norm_xn, norm_yn;
    logic           norm_done, busy;
    logic [1:0]     grant_id;
    logic           timeout_err, err_clr;
    arb_state_t     dbg_state;

    norm_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
        .resp_done(resp_done), .resp_xn(resp_xn), .resp_yn(resp_yn),
        .norm_start(norm_start), .norm_x(norm_x), .norm_y(norm_y),
        .norm_xn(norm_xn), .norm_yn(norm_yn), .norm_done(norm_done),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err),
        .err_clr(err_clr), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks, errors, cyc, start_cnt, done_cnt, last_start_cyc, last_done_cyc;
    logic [W-1:0] last_xn, last_yn;
    logic         last_err;
    logic [67:0]  exp_q[$];
    bit           model_en, model_rand, spur;
    int           model_lat, mdl_cnt;
    logic [W-1:0] cap_x, cap_y;

    // Reference normalisation in real arithmetic, rounded half away from zero.
    function automatic logic [63:0] fx_norm(input logic [W-1:0] x, input logic [W-1:0] y);
        real xr, yr, m;
        logic [W-1:0] xn, yn;
        xr = $itor($signed(x)) / 65536.0;
        yr = $itor($signed(y)) / 65536.0;
        m  = $sqrt(xr * xr + yr * yr);
        if (m == 0.0) return 64'h0;
        xn = W'($rtoi(xr / m * 65536.0 + ((xr >= 0.0) ? 0.5 : -0.5)));
        yn = W'($rtoi(yr / m * 65536.0 + ((yr >= 0.0) ? 0.5 : -0.5)));
        return {xn, yn};
    endfunction

    function automatic logic [67:0] make_exp(input int owner, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [3:0] oh;
        oh = 4'(1 << owner);
        return {oh, fx_norm(x, y)};
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: sample outputs at the falling edge, score responses, then
    // advance the behavioural norm unit.
    task automatic tick();
        logic [67:0] e;
        logic [63:0] r;
        @(negedge clk);
        cyc++;
        if (norm_start === 1'b1) begin
            start_cnt++;
            last_start_cyc = cyc;
        end
        if (resp_done !== '0) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_xn  = resp_xn;
            last_yn  = resp_yn;
            last_err = timeout_err;
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", {resp_done, resp_xn, resp_yn}, 68'h0);
            end else begin
                e = exp_q.pop_front();
                chk("resp", {resp_done, resp_xn, resp_yn}, e);
            end
        end
        norm_done = 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                r = fx_norm(cap_x, cap_y);
                norm_done = 1'b1;
                norm_xn = r[63:32];
                norm_yn = r[31:0];
            end
        end else if (norm_start === 1'b1 && model_en) begin
            cap_x   = norm_x;
            cap_y   = norm_y;
            mdl_cnt = model_rand ? int'($urandom_range(1, 6)) : model_lat;
        end
        if (spur) begin
            norm_done = 1'b1;
            norm_xn   = 32'h1234_5678;
            norm_yn   = 32'h8765_4321;
            spur      = 1'b0;
        end
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic wait_start(input string tag, input int budget);
        int s0 = start_cnt;
        int n  = 0;
        while (start_cnt == s0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 68'(start_cnt - s0), 68'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 68'(done_cnt - d0), 68'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        mdl_cnt = 0;
        norm_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, s, dc, sb, db, xi, yi;
        logic [W-1:0] ox [N];
        logic [W-1:0] oy [N];
        checks = 0; errors = 0; cyc = 0; start_cnt = 0; done_cnt = 0;
        last_start_cyc = -1; last_done_cyc = -1; last_xn = '0; last_yn = '0; last_err = 1'b0;
        rst_n = 1'b0; req = '0; req_x = '0; req_y = '0; err_clr = 1'b0;
        norm_done = 1'b0; norm_xn = '0; norm_yn = '0;
        model_en = 1'b1; model_rand = 1'b0; model_lat = 10; spur = 1'b0; mdl_cnt = 0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_norm_start", norm_start, 0);
        chk("rst_resp_done", resp_done, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_norm_xy", {norm_x, norm_y}, 0);
        chk("rst_resp_xy", {resp_xn, resp_yn}, 0);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        tick();

        // Single request, latency 10
        set_slot(2, 32'h0003_0000, 32'h0004_0000);
        exp_q.push_back(make_exp(2, 32'h0003_0000, 32'h0004_0000));
        req = 4'b0100;
        c0 = cyc;
        wait_start("single_start_seen", 5);
        chk("single_start_lat", last_start_cyc, c0 + 1);
        chk("single_norm_xy", {norm_x, norm_y}, {32'h0003_0000, 32'h0004_0000});
        chk("single_grant", grant_id, 2);
        wait_done("single_done_seen", 30);
        req = '0;
        chk("single_done_lat", last_done_cyc, c0 + 12);
        chk("single_xn", last_xn, 32'h0000_999A);
        chk("single_yn", last_yn, 32'h0000_CCCD);

        // All four from reset, held: grants 0,1,2,3,0
        do_reset();
        model_rand = 1'b1;
        for (int i = 0; i < N; i++) begin
            xi = int'($urandom_range(0, 400)) - 200;
            yi = int'($urandom_range(0, 400)) - 200;
            ox[i] = W'(xi) << 16;
            oy[i] = W'(yi) << 16;
            set_slot(i, ox[i], oy[i]);
        end
        for (int k = 0; k < 5; k++) exp_q.push_back(make_exp(k % N, ox[k % N], oy[k % N]));
        sb = start_cnt;
        db = done_cnt;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr_done_seen", 40);
            if (k == 4) begin
                req = '0;
            end else begin
                dc = last_done_cyc;
                tick();
                tick();
                chk("rr_gap", last_start_cyc, dc + 2);
            end
        end
        repeat (4) tick();
        chk("rr_start_count", start_cnt - sb, 5);
        chk("rr_done_count", done_cnt - db, 5);
        model_rand = 1'b0;

        // Watchdog: norm never answers
        model_en = 1'b0;
        set_slot(0, 32'h0001_0000, 32'h0002_0000);
        exp_q.push_back({4'b0001, 64'h0});
        req = 4'b0001;
        wait_start("wd_start_seen", 5);
        s = last_start_cyc;
        wait_done("wd_done_seen", 40);
        req = '0;
        chk("wd_latency", last_done_cyc, s + 17);
        chk("wd_err_at_resp", last_err, 1);
        tick();
        tick();
        chk("wd_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("wd_clear", timeout_err, 0);

        // Done on the timeout cycle wins
        model_en = 1'b1;
        model_lat = 16;
        set_slot(1, 32'h0006_0000, 32'h0008_0000);
        exp_q.push_back(make_exp(1, 32'h0006_0000, 32'h0008_0000));
        req = 4'b0010;
        wait_start("edge_start_seen", 5);
        s = last_start_cyc;
        wait_done("edge_done_seen", 40);
        req = '0;
        chk("edge_latency", last_done_cyc, s + 17);
        chk("edge_no_err", last_err, 0);

        // Early drop with operand change
        model_lat = 5;
        set_slot(1, 32'h0001_0000, 32'hFFFF_0000);
        exp_q.push_back(make_exp(1, 32'h0001_0000, 32'hFFFF_0000));
        req = 4'b0010;
        wait_start("drop_start_seen", 5);
        tick();
        tick();
        req = '0;
        set_slot(1, 32'h7777_0000, 32'h0123_0000);
        tick();
        chk("drop_norm_xy_stable", {norm_x, norm_y}, {32'h0001_0000, 32'hFFFF_0000});
        wait_done("drop_done_seen", 20);

        // Spurious done in IDLE
        tick();
        db = done_cnt;
        spur = 1'b1;
        repeat (3) tick();
        chk("spur_idle_no_resp", done_cnt - db, 0);
        chk("spur_idle_state", dbg_state, IDLE);

        // Spurious done in ISSUE
        model_lat = 6;
        set_slot(3, 32'h0005_0000, 32'h000C_0000);
        exp_q.push_back(make_exp(3, 32'h0005_0000, 32'h000C_0000));
        req = 4'b1000;
        c0 = cyc;
        spur = 1'b1;
        wait_start("spur_issue_start", 5);
        chk("spur_issue_start_lat", last_start_cyc, c0 + 1);
        wait_done("spur_issue_done", 20);
        req = '0;
        chk("spur_issue_done_lat", last_done_cyc, c0 + 8);

        // Reset mid-WAIT, then ptr must restart at 0
        model_lat = 10;
        set_slot(2, 32'h0002_0000, 32'h0002_0000);
        req = 4'b0100;
        wait_start("rstw_start_seen", 5);
        repeat (3) tick();
        chk("rstw_in_wait", dbg_state, WAIT);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_norm_start", norm_start, 0);
        chk("rstw_state", dbg_state, IDLE);
        mdl_cnt = 0;
        exp_q.delete();
        req = 4'b1000;
        repeat (3) tick();
        set_slot(0, 32'h0000_8000, 32'h0000_0000);
        set_slot(3, 32'hFFFD_0000, 32'h0004_0000);
        exp_q.push_back(make_exp(0, 32'h0000_8000, 32'h0000_0000));
        exp_q.push_back(make_exp(3, 32'hFFFD_0000, 32'h0004_0000));
        req = 4'b1001;
        rst_n = 1'b1;
        wait_done("rstw_first_done", 30);
        req = 4'b1000;
        wait_done("rstw_second_done", 30);
        req = '0;
        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
